// File: rtl/vwb_port_sequencer_pkg.sv
// Shared widths and helpers for the vector/scalar writeback port sequencer.
// Optional feature macro: VWB_HAZARD_QUERY_EN (see vwb_port_sequencer.sv).
package vwb_port_sequencer_pkg;

   localparam int DATA_W = 16;                 // lane / scalar data width
   localparam int LANES  = 4;                  // lanes per vector register
   localparam int VIDX_W = 6;                  // vector register index width
   localparam int SIDX_W = 4;                  // scalar register index width
   localparam int DEPTH  = 2;                  // vector queue entries (power of 2)
   localparam int LANE_W = $clog2(LANES);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);

   // Index of the lowest set bit; a zero mask yields lane 0 (never used that way).
   function automatic logic [LANE_W-1:0] lowestSetLane(input logic [LANES-1:0] mask);
      lowestSetLane = '0;
      for (int k = LANES - 1; k >= 0; k--) begin
         if (mask[k]) lowestSetLane = LANE_W'(k);
      end
   endfunction

endpackage

// File: rtl/vwb_vec_queue.sv
// Circular buffer of pending vector writebacks {idx, residual mask, data}.
// The head's residual mask is rewritten as lanes drain; the entry pops with its last lane.
module vwb_vec_queue
   import vwb_port_sequencer_pkg::*;
(
   input  logic                      clk,
   input  logic                      rstN,
   input  logic                      push,
   input  logic [VIDX_W-1:0]         pushIdx,
   input  logic [LANES-1:0]          pushMask,
   input  logic [DATA_W*LANES-1:0]   pushData,
   input  logic                      pop,
   input  logic                      maskWe,
   input  logic [LANES-1:0]          maskNew,
   output logic [CNT_W-1:0]          count,
   output logic [VIDX_W-1:0]         headIdx,
   output logic [LANES-1:0]          headMask,
   output logic [DATA_W*LANES-1:0]   headData,
   output logic [DEPTH-1:0]          entryValid,
   output logic [DEPTH*VIDX_W-1:0]   entryIdx
);

   logic [VIDX_W-1:0]       idxQ  [DEPTH];
   logic [LANES-1:0]        maskQ [DEPTH];
   logic [DATA_W*LANES-1:0] dataQ [DEPTH];
   logic [PTR_W-1:0]        wrPtr;
   logic [PTR_W-1:0]        rdPtr;

   // Storage, pointers and occupancy; push never targets the head slot being popped.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wrPtr      <= '0;
         rdPtr      <= '0;
         count      <= '0;
         entryValid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            idxQ[i]  <= '0;
            maskQ[i] <= '0;
            dataQ[i] <= '0;
         end
      end else begin
         if (push) begin
            idxQ[wrPtr]       <= pushIdx;
            maskQ[wrPtr]      <= pushMask;
            dataQ[wrPtr]      <= pushData;
            entryValid[wrPtr] <= 1'b1;
            wrPtr             <= wrPtr + 1'b1;
         end
         if (pop) begin
            entryValid[rdPtr] <= 1'b0;
            rdPtr             <= rdPtr + 1'b1;
         end else if (maskWe) begin
            maskQ[rdPtr] <= maskNew;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign headIdx  = idxQ[rdPtr];
   assign headMask = maskQ[rdPtr];
   assign headData = dataQ[rdPtr];

   // Flatten per-entry indices for the hazard compare.
   always_comb begin
      entryIdx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         entryIdx[i*VIDX_W +: VIDX_W] = idxQ[i];
      end
   end

endmodule

// File: rtl/vwb_port_sequencer.sv
// Arbitrates the single register-file write port between scalar writebacks and
// queued vector writebacks (drained one lane per cycle, lowest lane first).
// Optional feature macro: VWB_HAZARD_QUERY_EN -- exact per-index hazard query;
// when undefined O_QHit is the conservative O_Busy.
//
// Vector handshake: a transfer happens on a rising edge where I_VEnable and
// O_VReady are both high; O_VReady depends only on I_LOCK, reset and the
// registered queue count, never on I_VEnable. Scalar writes have no handshake
// and always win the port.
module vwb_port_sequencer
   import vwb_port_sequencer_pkg::*;
(
   input  logic                     I_CLOCK,
   input  logic                     I_RESET_N,
   input  logic                     I_LOCK,
   input  logic                     I_SEnable,
   input  logic [SIDX_W-1:0]        I_SRegIdx,
   input  logic [DATA_W-1:0]        I_SData,
   input  logic                     I_VEnable,
   input  logic [VIDX_W-1:0]        I_VRegIdx,
   input  logic [LANES-1:0]         I_VMask,
   input  logic [DATA_W*LANES-1:0]  I_VData,
   output logic                     O_VReady,
   output logic                     O_WrEnable,
   output logic                     O_WrIsVector,
   output logic [VIDX_W-1:0]        O_WrRegIdx,
   output logic [1:0]               O_WrLane,
   output logic [DATA_W-1:0]        O_WrData,
   output logic                     O_Busy,
   input  logic [VIDX_W-1:0]        I_QRegIdx,
   output logic                     O_QHit
);

   logic [CNT_W-1:0]         count;
   logic [VIDX_W-1:0]        headIdx;
   logic [LANES-1:0]         headMask;
   logic [DATA_W*LANES-1:0]  headData;
   logic [DEPTH-1:0]         entryValid;
   logic [DEPTH*VIDX_W-1:0]  entryIdx;
   logic                     qNotEmpty;
   logic                     push;
   logic                     pop;
   logic                     maskWe;
   logic                     issueScalar;
   logic                     issueVector;
   logic [LANE_W-1:0]        pickLane;
   logic [LANES-1:0]         residual;
   logic [DATA_W-1:0]        laneData;

   assign qNotEmpty = (count != '0);
   assign O_VReady  = I_RESET_N & I_LOCK & (count < CNT_W'(DEPTH));
   // An all-zero mask is consumed without occupying a queue slot.
   assign push      = I_VEnable & O_VReady & (I_VMask != '0);

   assign issueScalar = I_LOCK & I_SEnable;
   assign issueVector = I_LOCK & ~I_SEnable & qNotEmpty;
   assign pickLane    = lowestSetLane(headMask);
   assign residual    = headMask & ~(LANES'(1) << pickLane);
   assign pop         = issueVector & (residual == '0);
   assign maskWe      = issueVector & ~pop;

   // Select the data of the lane being issued from the head entry.
   always_comb begin
      laneData = headData[DATA_W*pickLane +: DATA_W];
   end

   vwb_vec_queue uQueue (
      .clk        (I_CLOCK),
      .rstN       (I_RESET_N),
      .push       (push),
      .pushIdx    (I_VRegIdx),
      .pushMask   (I_VMask),
      .pushData   (I_VData),
      .pop        (pop),
      .maskWe     (maskWe),
      .maskNew    (residual),
      .count      (count),
      .headIdx    (headIdx),
      .headMask   (headMask),
      .headData   (headData),
      .entryValid (entryValid),
      .entryIdx   (entryIdx)
   );

   // Registered write port: strobe every cycle, payload held while idle or frozen.
   always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         O_WrEnable   <= 1'b0;
         O_WrIsVector <= 1'b0;
         O_WrRegIdx   <= '0;
         O_WrLane     <= '0;
         O_WrData     <= '0;
      end else begin
         O_WrEnable <= issueScalar | issueVector;
         if (issueScalar) begin
            O_WrIsVector <= 1'b0;
            O_WrRegIdx   <= {{(VIDX_W-SIDX_W){1'b0}}, I_SRegIdx};
            O_WrLane     <= '0;
            O_WrData     <= I_SData;
         end else if (issueVector) begin
            O_WrIsVector <= 1'b1;
            O_WrRegIdx   <= headIdx;
            O_WrLane     <= pickLane;
            O_WrData     <= laneData;
         end
      end
   end

   assign O_Busy = qNotEmpty;

`ifdef VWB_HAZARD_QUERY_EN
   logic qHit;

   // Any valid queued entry targeting the queried vector register.
   always_comb begin
      qHit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entryValid[i] && (entryIdx[i*VIDX_W +: VIDX_W] == I_QRegIdx)) qHit = 1'b1;
      end
   end

   assign O_QHit = qHit;
`else
   logic unusedQuery;

   assign O_QHit      = qNotEmpty;
   assign unusedQuery = ^{I_QRegIdx, entryValid, entryIdx};
`endif

endmodule

// File: tb/tb_vwb_port_sequencer.sv
// Bench for vwb_port_sequencer: queue-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then a short random burst.
module tb_vwb_port_sequencer;

   typedef struct {
      logic [5:0]  idx;
      logic [3:0]  mask;
      logic [63:0] data;
   } ventry_t;

   logic        clk = 1'b0;
   logic        rstN = 1'b1;
   logic        lock = 1'b1;
   logic        sEn = 1'b0;
   logic [3:0]  sIdx = '0;
   logic [15:0] sData = '0;
   logic        vEn = 1'b0;
   logic [5:0]  vIdx = '0;
   logic [3:0]  vMask = '0;
   logic [63:0] vData = '0;
   logic [5:0]  qIdx = '0;
   logic        vReady, wrEn, wrIsVec, busy, qHit;
   logic [5:0]  wrIdx;
   logic [1:0]  wrLane;
   logic [15:0] wrData;

   int nCompared = 0;
   int nMismatched = 0;
   bit checkOn = 1'b0;
   int waits;

   vwb_port_sequencer dut (
      .I_CLOCK(clk), .I_RESET_N(rstN), .I_LOCK(lock),
      .I_SEnable(sEn), .I_SRegIdx(sIdx), .I_SData(sData),
      .I_VEnable(vEn), .I_VRegIdx(vIdx), .I_VMask(vMask), .I_VData(vData),
      .O_VReady(vReady), .O_WrEnable(wrEn), .O_WrIsVector(wrIsVec),
      .O_WrRegIdx(wrIdx), .O_WrLane(wrLane), .O_WrData(wrData),
      .O_Busy(busy), .I_QRegIdx(qIdx), .O_QHit(qHit)
   );

   // Clock
   always #5 clk = ~clk;

   // Reference model: pending vector writes as a plain queue of entries.
   ventry_t     mq[$];
   ventry_t     headE;
   ventry_t     newE;
   logic        expEn = 1'b0, expIsVec = 1'b0;
   logic [5:0]  expIdx = '0;
   logic [1:0]  expLane = '0;
   logic [15:0] expData = '0;
   bit          readyNow;
   int          mLane;

   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         mq.delete();
         expEn = 1'b0; expIsVec = 1'b0; expIdx = '0; expLane = '0; expData = '0;
      end else begin
         readyNow = lock && (mq.size() < 2);
         expEn = 1'b0;
         if (lock && sEn) begin
            expEn = 1'b1; expIsVec = 1'b0; expIdx = {2'b00, sIdx}; expLane = 2'd0; expData = sData;
         end else if (lock && mq.size() > 0) begin
            headE = mq[0];
            mLane = -1;
            for (int b = 3; b >= 0; b--) if (headE.mask[b]) mLane = b;
            expEn = 1'b1; expIsVec = 1'b1; expIdx = headE.idx;
            expLane = mLane[1:0];
            expData = headE.data[16*mLane +: 16];
            headE.mask[mLane] = 1'b0;
            if (headE.mask == 4'b0000) void'(mq.pop_front());
            else mq[0] = headE;
         end
         if (vEn && readyNow && vMask != 4'b0000) begin
            newE.idx = vIdx; newE.mask = vMask; newE.data = vData;
            mq.push_back(newE);
         end
      end
   end

   function automatic logic modelQHit(input logic [5:0] q);
`ifdef VWB_HAZARD_QUERY_EN
      foreach (mq[i]) if (mq[i].idx == q) return 1'b1;
      return 1'b0;
`else
      return mq.size() != 0;
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard compare on the falling edge, away from register updates.
   always @(negedge clk) begin
      if (checkOn) begin
         check("wrEnable", wrEn, expEn);
         check("wrIsVector", wrIsVec, expIsVec);
         check("wrRegIdx", wrIdx, expIdx);
         check("wrLane", wrLane, expLane);
         check("wrData", wrData, expData);
         check("busy", busy, mq.size() != 0);
         check("vReady", vReady, rstN && lock && (mq.size() < 2));
         check("qHit", qHit, modelQHit(qIdx));
      end
   end

   // Driver helpers: inputs change 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic waitReady();
      waits = 0;
      while (!vReady && waits < 20) begin
         cyc();
         waits++;
      end
      check("ready_wait", vReady, 1'b1);
   endtask

   task automatic sendVec(input logic [5:0] idx, input logic [3:0] mask, input logic [63:0] data);
      vEn = 1'b1; vIdx = idx; vMask = mask; vData = data;
      cyc();
      vEn = 1'b0;
   endtask

   task automatic drain();
      waits = 0;
      while (busy && waits < 40) begin
         cyc();
         waits++;
      end
      check("drain_done", busy, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1. reset with lock high
      #3 rstN = 1'b0;
      #1;
      checkOn = 1'b1;
      check("rst_vready", vReady, 1'b0);
      check("rst_wren", wrEn, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_qhit", qHit, 1'b0);
      cyc(); cyc();
      rstN = 1'b1;
      #1;
      check("rel_vready", vReady, 1'b1);
      check("rel_busy", busy, 1'b0);
      cyc();

      // 2. scalar R3
      sEn = 1'b1; sIdx = 4'd3; sData = 16'h1234;
      cyc();
      sEn = 1'b0;
      check("s_en", wrEn, 1'b1);
      check("s_isvec", wrIsVec, 1'b0);
      check("s_idx", wrIdx, 6'd3);
      check("s_lane", wrLane, 2'd0);
      check("s_data", wrData, 16'h1234);
      cyc();
      check("idle_en", wrEn, 1'b0);
      check("idle_hold", wrData, 16'h1234);

      // 3. V5 full mask, four lanes
      sendVec(6'd5, 4'b1111, 64'h4444_3333_2222_1111);
      check("v_lat_en", wrEn, 1'b0);
      check("v_busy", busy, 1'b1);
      cyc(); check("v_l0", {wrEn, wrIsVec, wrIdx, wrLane, wrData}, {1'b1, 1'b1, 6'd5, 2'd0, 16'h1111});
      cyc(); check("v_l1", {wrLane, wrData}, {2'd1, 16'h2222});
      cyc(); check("v_l2", {wrLane, wrData}, {2'd2, 16'h3333});
      check("v_busy_mid", busy, 1'b1);
      cyc(); check("v_l3", {wrLane, wrData}, {2'd3, 16'h4444});
      check("v_busy_end", busy, 1'b0);
      cyc();

      // 4. V2 mask 1010 with a scalar R7 in the first drain cycle
      sendVec(6'd2, 4'b1010, 64'hdddd_cccc_bbbb_aaaa);
      sEn = 1'b1; sIdx = 4'd7; sData = 16'h7777;
      cyc();
      sEn = 1'b0;
      check("b_scalar", {wrEn, wrIsVec, wrIdx, wrData}, {1'b1, 1'b0, 6'd7, 16'h7777});
      cyc(); check("b_l1", {wrIsVec, wrIdx, wrLane, wrData}, {1'b1, 6'd2, 2'd1, 16'hbbbb});
      cyc(); check("b_l3", {wrIsVec, wrIdx, wrLane, wrData}, {1'b1, 6'd2, 2'd3, 16'hdddd});
      cyc(); check("b_idle", {wrEn, busy}, 2'b00);

      // zero-mask accept consumes nothing
      sendVec(6'd4, 4'b0000, 64'hffff_ffff_ffff_ffff);
      check("z_busy", busy, 1'b0);
      cyc(); check("z_en", wrEn, 1'b0);

      // 5. fill, back-pressure, wrap over five entries
      vEn = 1'b1; vIdx = 6'd10; vMask = 4'b1111; vData = 64'h0a03_0a02_0a01_0a00;
      cyc();
      vIdx = 6'd11; vData = 64'h0b03_0b02_0b01_0b00;
      cyc();
      check("full_ready", vReady, 1'b0);
      vIdx = 6'd12; vData = 64'h0c03_0c02_0c01_0c00;
      waits = 0;
      while (!vReady && waits < 20) begin
         cyc();
         waits++;
      end
      check("third_wait", waits, 3);
      cyc();
      vIdx = 6'd13; vMask = 4'b0101; vData = 64'h0d03_0d02_0d01_0d00;
      waitReady(); cyc();
      vIdx = 6'd14; vMask = 4'b1000; vData = 64'h0e03_0e02_0e01_0e00;
      waitReady(); cyc();
      vEn = 1'b0;
      drain();
      cyc();

      // freeze mid-drain
      sendVec(6'd9, 4'b0110, 64'h9999_8888_7777_6666);
      cyc(); check("f_l1", {wrLane, wrData}, {2'd1, 16'h7777});
      lock = 1'b0;
      cyc(); check("f_frozen", wrEn, 1'b0);
      check("f_busy", busy, 1'b1);
      cyc();
      lock = 1'b1;
      cyc(); check("f_l2", {wrEn, wrLane, wrData}, {1'b1, 2'd2, 16'h8888});
      cyc();

      // 6. hazard query, then reset mid-drain
      qIdx = 6'd5;
      sendVec(6'd5, 4'b1111, 64'h4444_3333_2222_1111);
      check("q_hit5", qHit, 1'b1);
      qIdx = 6'd6;
      #1;
`ifdef VWB_HAZARD_QUERY_EN
      check("q_hit6", qHit, 1'b0);
`else
      check("q_hit6", qHit, 1'b1);
`endif
      #1;
      @(posedge clk); #1;
      check("r_l0", {wrEn, wrData}, {1'b1, 16'h1111});
      rstN = 1'b0;
      #1;
      check("r_en", wrEn, 1'b0);
      check("r_data", wrData, 16'h0000);
      check("r_busy", busy, 1'b0);
      check("r_ready", vReady, 1'b0);
      cyc();
      rstN = 1'b1;
      cyc(); check("r_nolane", wrEn, 1'b0);
      cyc(); check("r_nolane2", wrEn, 1'b0);

      // random burst checked by the scoreboard
      for (int c = 0; c < 300; c++) begin
         lock  = ($urandom_range(0, 9) != 0);
         sEn   = ($urandom_range(0, 3) == 0);
         sIdx  = 4'($urandom_range(0, 15));
         sData = 16'($urandom());
         vEn   = ($urandom_range(0, 1) == 1);
         vIdx  = 6'($urandom_range(0, 7));
         vMask = 4'($urandom_range(0, 15));
         vData = {32'($urandom()), 32'($urandom())};
         qIdx  = 6'($urandom_range(0, 7));
         cyc();
      end
      lock = 1'b1; sEn = 1'b0; vEn = 1'b0;
      drain();
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
